la_capture_core: RTL and testbench
==================================

// Module: la_capture_core
// PURPOSE
//  Next-generation single-clock logic-analyzer capture engine: parametrised sample width/depth,
//  per-bit level/edge trigger, N-th-match repeat, programmable pre-trigger window in a circular
//  buffer. Sits behind the wishbone logic-analyzer register slave.
//  After capture, the host drains the buffer oldest-first through a strobe/valid read port.
// PARAMETERS
//  CAPTURE_WIDTH  32  bits per sample (1..32)
//  CAPTURE_DEPTH  10  log2 of buffer samples; buffer holds N = 2**CAPTURE_DEPTH
// PORTS
//  clk                   in   1       single clock; capture and readout both run on it
//  rst_n                 in   1       asynchronous, active-low reset
//  cap_data              in   CW      sampled signals
//  cap_external_trigger  in   1       level trigger; OR'd with pattern match
//  trigger               in   CW      level value / edge polarity (1=rise)
//  trigger_mask          in   CW      1 = bit participates in match
//  trigger_edge          in   CW      1 = edge trigger, 0 = level
//  both_edges            in   CW      1 = either edge (when trigger_edge=1)
//  pre_trigger           in   CD      samples kept before trigger sample
//  repeat_count          in   32      matches to skip; fires on match repeat_count+1
//  clk_div               in   16      sample every clk_div+1 cycles (see CONFIGURATION)
//  enable                in   1       0 aborts to IDLE; 1 arms
//  restart               in   1       DONE -> re-arm pulse
//  finished              out  1       1 in DONE
//  triggered             out  1       1 from trigger sample until IDLE
//  data_out_read_strobe  in   1       pop one sample (DONE only)
//  data_out_valid        out  1       data_out valid, 1-cycle pulse
//  data_out              out  CW      sample, oldest first
//  data_out_read_size    out  32      constant N
//  data_out_empty        out  1       1 when all N read, or not DONE
// BEHAVIOUR
//  Reset: all outputs 0 except data_out_read_size=N, data_out_empty=1; state IDLE.
//  States: IDLE -> PREFILL -> WAIT_TRIG -> POST -> DONE.
//  IDLE: enable=1 -> latch trigger/mask/edge/both_edges/pre/repeat into shadow regs; -> PREFILL.
//    Config changes after arm are ignored until the next arm.
//  Sample tick: every cycle, or per divider. Each tick writes cap_data at wr_ptr, wr_ptr++ mod N.
//  PREFILL: count ticks; after pre_c ticks -> WAIT_TRIG (pre_c=0 -> straight to WAIT_TRIG).
//    Trigger is NOT evaluated in PREFILL.
//  Match per bit: mask=0 ->1; edge ->(both & any edge)|(trig & rise)|(~trig & fall);
//    else level equality. Overall match = AND of all bits | cap_external_trigger.
//  Edges are vs previous tick's sample; suppressed on the first tick after arm.
//  WAIT_TRIG, tick & match: rep_cnt==0 -> trig_addr=wr_ptr, triggered=1, -> POST;
//    else rep_cnt--. The matching sample is written either way.
//  pre_c = min(pre_trigger, N-1). POST: write N-1-pre_c further ticks -> DONE.
//    Total retained = N; start_addr = trig_addr - pre_c (mod N); trigger sample at index pre_c.
//  DONE: finished=1; rd_ptr=start_addr, rd_cnt=0, data_out_empty=0.
//  Read: strobe & !empty -> RAM read at rd_ptr; data_out/valid 1 cycle later; rd_ptr++, rd_cnt++.
//    empty=1 after N pops; strobes when empty or not DONE are ignored (no valid).
//  enable=0 in any state -> IDLE next cycle; triggered, finished cleared; buffer contents undefined.
//  DONE & restart & enable -> re-arm as from IDLE (fresh shadow latch). restart and enable=0 together -> IDLE.
//  Same-cycle match and enable falling -> enable wins.
//  rep_cnt is 32-bit; no wrap: 0 is terminal.
// CONFIGURATION
//  LA_DECIMATE_EN defined: 16-bit divider counter; tick when cnt==clk_div_latched (latched at arm),
//    cnt cleared on arm. clk_div=0 -> every cycle.
//  Not defined: clk_div port present but ignored; tick every cycle in PREFILL/WAIT_TRIG/POST.
// STRUCTURE
//  Package la_pkg: state enum, LA_MAX_WIDTH=32, function la_bit_match(data,prev,trig,mask,edge,both).
//  Sub-module la_sample_ram (simple dual-port, write-first, 1-cycle registered read, CW x N).
//  Top: control FSM, pointers, trigger compare, read port.
// TESTING
//  1 CW=8,CD=4,pre=4,rep=0,level trig=8'hA5 mask=FF, ramp data 0..;
//    A5 at cycle k -> reads give 0xA1..0xB0, 5th = 0xA5.
//  2 rise edge bit0, rep=2, toggling bit0 -> fires on 3rd rising edge; triggered rises that tick.
//  3 pre=15 (N-1) -> trigger sample is last read; pre=0 -> first read.
//  4 Pull enable low during POST -> IDLE, finished=0; strobes produce no valid.
//  5 LA_DECIMATE_EN, clk_div=3, ramp per cycle -> stored samples differ by 4.
//  6 17 strobes after DONE (N=16) -> 16 valids, empty=1, 17th ignored; restart re-captures.

Source files
------------

// File: rtl/la_pkg.sv
// Shared types and helpers for the logic-analyzer capture engine:
// FSM state encoding, maximum sample width, per-bit trigger compare.
package la_pkg;

    localparam int LA_MAX_WIDTH = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREFILL,
        ST_WAIT_TRIG,
        ST_POST,
        ST_DONE
    } la_state_t;

    // Per-bit match vector. Unmasked bits always match, so narrower
    // samples zero-extended to LA_MAX_WIDTH reduce cleanly with &.
    function automatic logic [LA_MAX_WIDTH-1:0] la_bit_match(
        input logic [LA_MAX_WIDTH-1:0] data,
        input logic [LA_MAX_WIDTH-1:0] prev,
        input logic [LA_MAX_WIDTH-1:0] trig,
        input logic [LA_MAX_WIDTH-1:0] mask,
        input logic [LA_MAX_WIDTH-1:0] edg,
        input logic [LA_MAX_WIDTH-1:0] both
    );
        logic [LA_MAX_WIDTH-1:0] rise;
        logic [LA_MAX_WIDTH-1:0] fall;
        logic [LA_MAX_WIDTH-1:0] edm;
        logic [LA_MAX_WIDTH-1:0] lvl;
        rise = data & ~prev;
        fall = ~data & prev;
        edm  = (both & (rise | fall)) | (trig & rise) | (~trig & fall);
        lvl  = ~(data ^ trig);
        return ~mask | (mask & ((edg & edm) | (~edg & lvl)));
    endfunction

endpackage

// File: rtl/la_sample_ram.sv
// Sample buffer: simple dual-port RAM, write-first, registered read.
// Ports: wr_en/wr_addr/wr_data write side; rd_en/rd_addr -> rd_data next cycle.
module la_sample_ram
    import la_pkg::*;
#(
    parameter int W  = 32,
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [W-1:0]  wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [W-1:0]  rd_data
);

    logic [W-1:0] mem [0:(1<<AW)-1];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= (wr_en && wr_addr == rd_addr) ? wr_data : mem[rd_addr];
        end
    end

endmodule

// File: rtl/la_capture_core.sv
// Logic-analyzer capture engine: circular pre-trigger buffer, per-bit
// level/edge trigger with repeat count, oldest-first strobe/valid readout.
// Ports: cap_data/cap_external_trigger sampled inputs; trigger, trigger_mask,
//   trigger_edge, both_edges, pre_trigger, repeat_count, clk_div config
//   (latched on arm); enable/restart control; finished/triggered status;
//   data_out_read_strobe -> data_out_valid/data_out; data_out_read_size,
//   data_out_empty.
// Build option: LA_DECIMATE_EN enables the clk_div sample divider.
module la_capture_core
    import la_pkg::*;
#(
    parameter int CAPTURE_WIDTH = 32,
    parameter int CAPTURE_DEPTH = 10
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [CAPTURE_WIDTH-1:0] cap_data,
    input  logic                     cap_external_trigger,
    input  logic [CAPTURE_WIDTH-1:0] trigger,
    input  logic [CAPTURE_WIDTH-1:0] trigger_mask,
    input  logic [CAPTURE_WIDTH-1:0] trigger_edge,
    input  logic [CAPTURE_WIDTH-1:0] both_edges,
    input  logic [CAPTURE_DEPTH-1:0] pre_trigger,
    input  logic [31:0]              repeat_count,
    input  logic [15:0]              clk_div,
    input  logic                     enable,
    input  logic                     restart,
    output logic                     finished,
    output logic                     triggered,
    input  logic                     data_out_read_strobe,
    output logic                     data_out_valid,
    output logic [CAPTURE_WIDTH-1:0] data_out,
    output logic [31:0]              data_out_read_size,
    output logic                     data_out_empty
);

    localparam int CW = CAPTURE_WIDTH;
    localparam int CD = CAPTURE_DEPTH;
    localparam int N  = 1 << CD;
    localparam logic [CD-1:0] LAST  = CD'(N - 1);
    localparam logic [CD:0]   N_CNT = (CD + 1)'(N);

    la_state_t state, state_nx;

    logic [CW-1:0] trig_s, mask_s, edge_s, both_s, prev;
    logic [CD-1:0] pre_s, pre_cnt, post_cnt, post_need;
    logic [CD-1:0] wr_ptr, trig_addr, rd_ptr;
    logic [CD:0]   rd_cnt;
    logic [31:0]   rep_cnt;
    logic          first, trig_q, valid_q;

    logic          active, tick, arm, hit, fire;
    logic          pre_last, post_last, empty, rd_en;
    logic [CW-1:0] prev_eff;
    logic [LA_MAX_WIDTH-1:0] bits;

    assign active = (state == ST_PREFILL) || (state == ST_WAIT_TRIG)
                 || (state == ST_POST);
    assign arm = enable && ((state == ST_IDLE)
                 || (state == ST_DONE && restart));

`ifdef LA_DECIMATE_EN
    logic [15:0] div_cnt, div_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
            div_s   <= '0;
        end else if (arm) begin
            div_cnt <= '0;
            div_s   <= clk_div;
        end else if (active) begin
            div_cnt <= (div_cnt == div_s) ? 16'd0 : div_cnt + 16'd1;
        end
    end

    assign tick = active && (div_cnt == div_s);
`else
    logic unused_clk_div;
    assign unused_clk_div = ^clk_div;
    assign tick = active;
`endif

    // First tick after arm has no valid previous sample: compare
    // against itself so no edge is seen.
    assign prev_eff = first ? cap_data : prev;
    assign bits = la_bit_match(32'(cap_data), 32'(prev_eff), 32'(trig_s),
                               32'(mask_s), 32'(edge_s), 32'(both_s));
    assign hit  = (&bits) | cap_external_trigger;
    assign fire = (state == ST_WAIT_TRIG) && tick && hit && (rep_cnt == '0);

    assign post_need = ~pre_s;
    assign pre_last  = tick && (pre_cnt == pre_s - CD'(1));
    assign post_last = tick && (post_cnt == post_need - CD'(1));

    assign empty = (state != ST_DONE) || (rd_cnt == N_CNT);
    assign rd_en = (state == ST_DONE) && enable && !restart
                && data_out_read_strobe && !empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (!enable) begin
            state_nx = ST_IDLE;
        end else begin
            unique case (state)
                ST_IDLE:
                    state_nx = (pre_trigger == '0) ? ST_WAIT_TRIG : ST_PREFILL;
                ST_PREFILL:
                    if (pre_last) state_nx = ST_WAIT_TRIG;
                ST_WAIT_TRIG:
                    if (fire) state_nx = (pre_s == LAST) ? ST_DONE : ST_POST;
                ST_POST:
                    if (post_last) state_nx = ST_DONE;
                ST_DONE:
                    if (restart)
                        state_nx = (pre_trigger == '0) ? ST_WAIT_TRIG : ST_PREFILL;
                default:
                    state_nx = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trig_s    <= '0;
            mask_s    <= '0;
            edge_s    <= '0;
            both_s    <= '0;
            pre_s     <= '0;
            rep_cnt   <= '0;
            prev      <= '0;
            pre_cnt   <= '0;
            post_cnt  <= '0;
            wr_ptr    <= '0;
            trig_addr <= '0;
            rd_ptr    <= '0;
            rd_cnt    <= '0;
            first     <= 1'b0;
            trig_q    <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            valid_q <= rd_en;
            if (arm) begin
                trig_s   <= trigger;
                mask_s   <= trigger_mask;
                edge_s   <= trigger_edge;
                both_s   <= both_edges;
                pre_s    <= pre_trigger;
                rep_cnt  <= repeat_count;
                pre_cnt  <= '0;
                post_cnt <= '0;
                wr_ptr   <= '0;
                first    <= 1'b1;
                trig_q   <= 1'b0;
            end else if (!enable) begin
                trig_q <= 1'b0;
            end else begin
                if (tick) begin
                    wr_ptr <= wr_ptr + CD'(1);
                    prev   <= cap_data;
                    first  <= 1'b0;
                end
                if (state == ST_PREFILL && tick) pre_cnt <= pre_cnt + CD'(1);
                if (state == ST_WAIT_TRIG && tick && hit) begin
                    if (rep_cnt == '0) begin
                        trig_addr <= wr_ptr;
                        trig_q    <= 1'b1;
                    end else begin
                        rep_cnt <= rep_cnt - 32'd1;
                    end
                end
                if (state == ST_POST && tick) post_cnt <= post_cnt + CD'(1);
                // Oldest retained sample sits pre_c slots before the trigger.
                if (state != ST_DONE && state_nx == ST_DONE) begin
                    rd_ptr <= (fire ? wr_ptr : trig_addr) - pre_s;
                    rd_cnt <= '0;
                end
                if (rd_en) begin
                    rd_ptr <= rd_ptr + CD'(1);
                    rd_cnt <= rd_cnt + 1'b1;
                end
            end
        end
    end

    la_sample_ram #(
        .W  (CW),
        .AW (CD)
    ) u_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (tick),
        .wr_addr (wr_ptr),
        .wr_data (cap_data),
        .rd_en   (rd_en),
        .rd_addr (rd_ptr),
        .rd_data (data_out)
    );

    assign finished           = (state == ST_DONE);
    assign triggered          = trig_q;
    assign data_out_valid     = valid_q;
    assign data_out_read_size = 32'(N);
    assign data_out_empty     = empty;

endmodule

// File: tb/tb_la_capture_core.sv
// Directed bench for la_capture_core (CW=8, N=16).
// Decimation case compiled in only when LA_DECIMATE_EN is defined.
module tb_la_capture_core;

    localparam int CW = 8;
    localparam int CD = 4;
    localparam int N  = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [CW-1:0] cap_data;
    logic          ext;
    logic [CW-1:0] trig, mask, edg, both;
    logic [CD-1:0] pre;
    logic [31:0]   rep;
    logic [15:0]   div;
    logic          enable, restart, finished, triggered;
    logic          rs, valid, empty;
    logic [CW-1:0] data_out;
    logic [31:0]   rsize;

    la_capture_core #(
        .CAPTURE_WIDTH (CW),
        .CAPTURE_DEPTH (CD)
    ) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .cap_data             (cap_data),
        .cap_external_trigger (ext),
        .trigger              (trig),
        .trigger_mask         (mask),
        .trigger_edge         (edg),
        .both_edges           (both),
        .pre_trigger          (pre),
        .repeat_count         (rep),
        .clk_div              (div),
        .enable               (enable),
        .restart              (restart),
        .finished             (finished),
        .triggered            (triggered),
        .data_out_read_strobe (rs),
        .data_out_valid       (valid),
        .data_out             (data_out),
        .data_out_read_size   (rsize),
        .data_out_empty       (empty)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;
    int tmode  = 0;
    logic [CW-1:0] exp_q [N];

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] expv);
        checks++;
        if (obs !== expv) begin
            fails++;
            $display("FAIL %s: got %h want %h", tag, obs, expv);
        end
    endtask

    // One clock; inputs change 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
        if (tmode == 1) cap_data = cap_data + 8'd1;
        else if (tmode == 2) cap_data[0] = ~cap_data[0];
    endtask

    task automatic setup(input logic [CD-1:0] p, input logic [31:0] r,
                         input logic [CW-1:0] t, input logic [CW-1:0] m,
                         input logic [CW-1:0] e, input logic [CW-1:0] b);
        pre = p; rep = r; trig = t; mask = m; edg = e; both = b;
    endtask

    task automatic go_idle();
        enable = 1'b0; restart = 1'b0; rs = 1'b0;
        step();
        step();
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!finished && n < 600) begin
            step();
            n++;
        end
        check(tag, 32'(finished), 32'd1);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i <= N; i++) begin
            rs = 1'b1;
            step();
            check({tag, "_valid"}, 32'(valid), 32'(i < N));
            if (i < N) check({tag, "_data"}, 32'(data_out), 32'(exp_q[i]));
            rs = 1'b0;
            step();
        end
        check({tag, "_empty"}, 32'(empty), 32'd1);
    endtask

    initial begin
        rst_n = 1'b0; cap_data = '0; ext = 1'b0; div = 16'd0;
        enable = 1'b0; restart = 1'b0; rs = 1'b0;
        setup(4'd0, 32'd0, 8'h00, 8'h00, 8'h00, 8'h00);
        step();
        step();
        check("rst_finished", 32'(finished), 32'd0);
        check("rst_triggered", 32'(triggered), 32'd0);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_data", 32'(data_out), 32'd0);
        check("rst_size", rsize, 32'd16);
        check("rst_empty", 32'(empty), 32'd1);
        rst_n = 1'b1;
        step();

        // Level trigger on A5, 4 samples of pre-trigger.
        cap_data = '0; tmode = 1;
        setup(4'd4, 32'd0, 8'hA5, 8'hFF, 8'h00, 8'h00);
        enable = 1'b1;
        step();
        wait_done("t1_done");
        check("t1_triggered", 32'(triggered), 32'd1);
        check("t1_empty0", 32'(empty), 32'd0);
        for (int i = 0; i < N; i++) exp_q[i] = 8'hA1 + 8'(i);
        drain("t1");

        // Restart re-captures with fresh config; later changes ignored.
        cap_data = '0;
        setup(4'd4, 32'd0, 8'h30, 8'hFF, 8'h00, 8'h00);
        restart = 1'b1;
        step();
        restart = 1'b0;
        trig = 8'hFF;
        check("t6_restart_fin", 32'(finished), 32'd0);
        wait_done("t6_done");
        for (int i = 0; i < N; i++) exp_q[i] = 8'h2C + 8'(i);
        drain("t6");

        // Rising edge on bit0, fire on 3rd match.
        go_idle();
        tmode = 0; cap_data = '0;
        setup(4'd0, 32'd2, 8'h01, 8'h01, 8'h01, 8'h00);
        enable = 1'b1;
        step();
        tmode = 2;
        for (int k = 1; k <= 6; k++) begin
            step();
            check("t2_triggered", 32'(triggered), 32'(k == 6));
        end
        wait_done("t2_done");
        for (int i = 0; i < N; i++) exp_q[i] = (i % 2 == 0) ? 8'h01 : 8'h00;
        drain("t2");

        // pre = N-1: trigger sample is the last read.
        go_idle();
        tmode = 1; cap_data = '0;
        setup(4'd15, 32'd0, 8'hA5, 8'hFF, 8'h00, 8'h00);
        enable = 1'b1;
        step();
        wait_done("t3a_done");
        for (int i = 0; i < N; i++) exp_q[i] = 8'h96 + 8'(i);
        drain("t3a");

        // pre = 0: trigger sample is the first read.
        go_idle();
        cap_data = '0;
        setup(4'd0, 32'd0, 8'hA5, 8'hFF, 8'h00, 8'h00);
        enable = 1'b1;
        step();
        wait_done("t3b_done");
        for (int i = 0; i < N; i++) exp_q[i] = 8'hA5 + 8'(i);
        drain("t3b");

        // Abort during POST.
        go_idle();
        cap_data = '0;
        setup(4'd0, 32'd0, 8'hA5, 8'hFF, 8'h00, 8'h00);
        enable = 1'b1;
        step();
        begin
            int n = 0;
            while (!triggered && n < 600) begin
                step();
                n++;
            end
        end
        check("t4_triggered", 32'(triggered), 32'd1);
        step();
        step();
        enable = 1'b0;
        step();
        check("t4_finished", 32'(finished), 32'd0);
        check("t4_triggered0", 32'(triggered), 32'd0);
        check("t4_empty", 32'(empty), 32'd1);
        for (int i = 0; i < 3; i++) begin
            rs = 1'b1;
            step();
            check("t4_novalid", 32'(valid), 32'd0);
        end
        rs = 1'b0;

`ifdef LA_DECIMATE_EN
        // Divide by 4: stored samples step by 4.
        go_idle();
        cap_data = '0; div = 16'd3;
        setup(4'd4, 32'd0, 8'h00, 8'h00, 8'h00, 8'h00);
        enable = 1'b1;
        step();
        wait_done("t5_done");
        for (int i = 0; i < N; i++) exp_q[i] = 8'(4 * (i + 1));
        drain("t5");
        div = 16'd0;
`endif

        go_idle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
